alu_host_driver: RTL and testbench

- Initiator side of the ALU operand/result bus: takes one request (op, operands) on a valid/ready port and drives BEGIN, op_code and inbus into the ALU, one operand word per cycle.
- Waits for END, captures the result words from outbus and presents them on a valid/ready response port.
- Sits between the test/host logic and the sequential ALU. Includes a watchdog so a hung ALU cannot lock the host.

---
 rtl/alu_bus_pkg.sv | 56 +++++
 rtl/alu_host_driver_if.sv | 29 ++
 rtl/alu_bus_watchdog.sv | 38 +++
 rtl/alu_host_driver.sv | 158 +++++++++++++++
 tb/tb_alu_host_driver.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU operand/result bus: opcodes, FSM states,
// request layout and per-opcode word counts.
package alu_bus_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STRT = 3'd1,
    ST_LD0  = 3'd2,
    ST_LD1  = 3'd3,
    ST_LD2  = 3'd4,
    ST_WAIT = 3'd5,
    ST_CAP1 = 3'd6,
    ST_RESP = 3'd7
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] x;
    logic [7:0]  y;
  } req_t;

  function automatic logic [1:0] load_words(input logic [1:0] op);
    return (op == OP_DIV) ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [1:0] result_words(input logic [1:0] op);
    return (op == OP_MUL || op == OP_DIV) ? 2'd2 : 2'd1;
  endfunction

  // Division sends the 16-bit dividend high byte first, then the divisor.
  function automatic logic [7:0] load_word(input req_t req, input logic [1:0] idx);
    logic [7:0] w;
    w = 8'h00;
    if (req.op == OP_DIV) begin
      case (idx)
        2'd0:    w = req.x[15:8];
        2'd1:    w = req.x[7:0];
        2'd2:    w = req.y;
        default: w = 8'h00;
      endcase
    end else begin
      case (idx)
        2'd0:    w = req.x[7:0];
        2'd1:    w = req.y;
        default: w = 8'h00;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/alu_host_driver_if.sv
// Request, ALU bus and response signals of the host driver.
// master = the driver itself, slave = host logic plus ALU around it.
interface alu_host_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_x;
  logic [7:0]  req_y;
  logic        BEGIN;
  logic [1:0]  op_code;
  logic [7:0]  inbus;
  logic [7:0]  outbus;
  logic        END;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_hi;
  logic [7:0]  resp_lo;
  logic        resp_err;

  modport master (
    input  req_valid, req_op, req_x, req_y, outbus, END, resp_ready,
    output req_ready, BEGIN, op_code, inbus, resp_valid, resp_hi, resp_lo, resp_err
  );

  modport slave (
    output req_valid, req_op, req_x, req_y, outbus, END, resp_ready,
    input  req_ready, BEGIN, op_code, inbus, resp_valid, resp_hi, resp_lo, resp_err
  );
endinterface

// File: rtl/alu_bus_watchdog.sv
// Cycle counter guarding the WAIT phase; expired_o flags the cycle in which
// the TIMEOUT-th enabled cycle is reached.
module alu_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'h00;
    end else if (en_i && count_q != 8'hFF) begin
      count_d = count_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of WAIT cycles already completed.
  assign expired_o = en_i && (count_q >= LIMIT);

endmodule

// File: rtl/alu_host_driver.sv
// Host-side initiator of the sequential ALU: serialises one request onto
// BEGIN/op_code/inbus, waits for END and returns the captured result words.
module alu_host_driver #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  alu_host_driver_if.master bus
);
  import alu_bus_pkg::*;

  state_e     state_q, state_d;
  req_t       req_q, req_d;
  logic [7:0] resp_hi_q, resp_hi_d;
  logic [7:0] resp_lo_q, resp_lo_d;
  logic       resp_err_q, resp_err_d;

  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  logic       req_ready;
  logic       begin_strobe;
  logic [1:0] op_code;
  logic [7:0] inbus;
  logic       resp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = ST_STRT;
      ST_STRT: state_d = ST_LD0;
      ST_LD0:  state_d = ST_LD1;
      ST_LD1:  state_d = (load_words(req_q.op) == 2'd3) ? ST_LD2 : ST_WAIT;
      ST_LD2:  state_d = ST_WAIT;
      ST_WAIT: begin
        // END has priority over a watchdog expiry in the same cycle.
        if (bus.END) begin
          state_d = (result_words(req_q.op) == 2'd2) ? ST_CAP1 : ST_RESP;
        end else if (wd_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_CAP1: state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : datapath_next
    req_d      = req_q;
    resp_hi_d  = resp_hi_q;
    resp_lo_d  = resp_lo_q;
    resp_err_d = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.op = bus.req_op;
          req_d.x  = bus.req_x;
          req_d.y  = bus.req_y;
        end
      end
      ST_WAIT: begin
        if (bus.END) begin
          resp_err_d = 1'b0;
          if (result_words(req_q.op) == 2'd2) begin
            resp_hi_d = bus.outbus;
          end else begin
            resp_hi_d = 8'h00;
            resp_lo_d = bus.outbus;
          end
        end else if (wd_expired) begin
          resp_err_d = 1'b1;
          resp_hi_d  = 8'h00;
          resp_lo_d  = 8'h00;
        end
      end
      ST_CAP1: resp_lo_d = bus.outbus;
      ST_RESP: if (bus.resp_ready) resp_err_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q      <= '0;
      resp_hi_q  <= 8'h00;
      resp_lo_q  <= 8'h00;
      resp_err_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      resp_hi_q  <= resp_hi_d;
      resp_lo_q  <= resp_lo_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_comb begin : outputs
    req_ready    = 1'b0;
    begin_strobe = 1'b0;
    op_code      = OP_ADD;
    inbus        = 8'h00;
    resp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_STRT: begin
        begin_strobe = 1'b1;
        op_code      = req_q.op;
      end
      ST_LD0: begin
        op_code = req_q.op;
        inbus   = load_word(req_q, 2'd0);
      end
      ST_LD1: begin
        op_code = req_q.op;
        inbus   = load_word(req_q, 2'd1);
      end
      ST_LD2: begin
        op_code = req_q.op;
        inbus   = load_word(req_q, 2'd2);
      end
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Restart the count on the transition into WAIT so each operation gets a full budget.
  assign wd_clr = (state_d == ST_WAIT) && (state_q != ST_WAIT);
  assign wd_en  = (state_q == ST_WAIT);

  alu_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  assign bus.req_ready  = req_ready;
  assign bus.BEGIN      = begin_strobe;
  assign bus.op_code    = op_code;
  assign bus.inbus      = inbus;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_hi    = resp_hi_q;
  assign bus.resp_lo    = resp_lo_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_host_driver.sv
// Scoreboard bench for alu_host_driver: stimulus pushes expected responses,
// an ALU model answers the bus, a monitor pops and compares each response.
module tb_alu_host_driver;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_host_driver_if bus();

  alu_host_driver #(.TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_resp = 0;
  bit model_on = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       err;
    int         due;
    int         hold;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] x;
    logic [7:0]  y;
    int          delay;
    bit          no_end;
  } job_t;

  exp_t sb_q[$];
  job_t alu_q[$];

  logic       end_m, end_s;
  logic [7:0] outbus_m, outbus_s;
  assign bus.END    = end_m | end_s;
  assign bus.outbus = outbus_m | outbus_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] exp_word(input job_t j, input int i);
    logic [7:0] w;
    w = 8'h00;
    if (j.op == 2'd3) begin
      if (i == 0) w = j.x[15:8];
      else if (i == 1) w = j.x[7:0];
      else w = j.y;
    end else begin
      w = (i == 0) ? j.x[7:0] : j.y;
    end
    return w;
  endfunction

  // Stimulus: called at a negedge, returns at a negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [7:0] y,
                       input int delay, input bit no_end, input int hold);
    exp_t e;
    job_t j;
    int   guard;
    int   lat;
    int   prod;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("FAIL req_accept: req_ready=%b after 500 cycles, expected 1", bus.req_ready);
    end else begin
      e.hold = hold;
      if (no_end) begin
        e.hi  = 8'h00;
        e.lo  = 8'h00;
        e.err = 1'b1;
        lat   = 3 + TMO + ((op == 2'd3) ? 1 : 0);
      end else begin
        e.err = 1'b0;
        e.hi  = 8'h00;
        case (op)
          2'd0: e.lo = 8'((int'(x[7:0]) + int'(y)) % 256);
          2'd1: e.lo = 8'((int'(x[7:0]) - int'(y) + 256) % 256);
          2'd2: begin
            prod = int'(x[7:0]) * int'(y);
            e.hi = 8'(prod / 256);
            e.lo = 8'(prod % 256);
          end
          default: begin
            e.hi = 8'(int'(x) % int'(y));
            e.lo = 8'((int'(x) / int'(y)) % 256);
          end
        endcase
        lat = 4 + delay + ((op >= 2'd2) ? 1 : 0) + ((op == 2'd3) ? 1 : 0);
      end
      e.due = cyc + 1 + lat;
      sb_q.push_back(e);
      j.op = op; j.x = x; j.y = y; j.delay = delay; j.no_end = no_end;
      alu_q.push_back(j);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || bus.req_ready !== 1'b1) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses still outstanding, expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // ALU model: collects the operand words and answers with plain arithmetic.
  initial begin : alu_model
    job_t       j;
    logic [7:0] w [3];
    logic [7:0] rh, rl;
    logic [15:0] p, dvd;
    int         nw;
    end_m    = 1'b0;
    outbus_m = 8'h00;
    forever begin
      @(negedge clk);
      if (model_on && bus.BEGIN === 1'b1) begin
        if (alu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL begin_no_job: BEGIN=1 with no request outstanding");
        end else begin
          j = alu_q.pop_front();
          check("strt_op_code", bus.op_code, j.op);
          check("strt_inbus", bus.inbus, 0);
          nw = (j.op == 2'd3) ? 3 : 2;
          for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            w[i] = bus.inbus;
            check("ld_begin", bus.BEGIN, 0);
            check("ld_op_code", bus.op_code, j.op);
            check("ld_inbus", bus.inbus, exp_word(j, i));
          end
          @(negedge clk);
          check("wait_inbus", bus.inbus, 0);
          check("wait_op_code", bus.op_code, 0);
          if (!j.no_end) begin
            repeat (j.delay) @(negedge clk);
            rh = 8'h00;
            case (j.op)
              2'd0: rl = w[0] + w[1];
              2'd1: rl = w[0] - w[1];
              2'd2: begin
                p  = 16'(w[0]) * 16'(w[1]);
                rh = p[15:8];
                rl = p[7:0];
              end
              default: begin
                dvd = {w[0], w[1]};
                p   = dvd % 16'(w[2]);
                rh  = p[7:0];
                p   = dvd / 16'(w[2]);
                rl  = p[7:0];
              end
            endcase
            end_m    = 1'b1;
            outbus_m = (j.op >= 2'd2) ? rh : rl;
            @(negedge clk);
            end_m    = 1'b0;
            outbus_m = (j.op >= 2'd2) ? rl : 8'h00;
            @(negedge clk);
            outbus_m = 8'h00;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard when a response appears, then applies back-pressure.
  initial begin : monitor
    exp_t       cur;
    bit         in_resp;
    bit         idle_chk;
    int         hold;
    logic [7:0] shi, slo;
    logic       serr;
    in_resp  = 1'b0;
    idle_chk = 1'b0;
    hold     = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        check("idle_after_handshake", bus.req_ready, 1);
        idle_chk = 1'b0;
      end
      if (in_resp && bus.resp_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL resp_dropped: resp_valid=%b before handshake, expected 1", bus.resp_valid);
        in_resp = 1'b0;
      end
      if (bus.resp_valid === 1'b1) begin
        if (!in_resp) begin
          in_resp = 1'b1;
          shi  = bus.resp_hi;
          slo  = bus.resp_lo;
          serr = bus.resp_err;
          n_resp++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: hi=%02h lo=%02h err=%b with nothing outstanding",
                     shi, slo, serr);
            hold = 0;
          end else begin
            cur = sb_q.pop_front();
            $display("resp %0d: hi=%02h lo=%02h err=%b at cycle %0d (expected hi=%02h lo=%02h err=%b at %0d)",
                     n_resp, shi, slo, serr, cyc, cur.hi, cur.lo, cur.err, cur.due);
            check("resp_hi", shi, cur.hi);
            check("resp_lo", slo, cur.lo);
            check("resp_err", serr, cur.err);
            check("latency", cyc, cur.due);
            hold = cur.hold;
          end
        end else begin
          check("resp_stable", {bus.resp_hi, bus.resp_lo, bus.resp_err}, {shi, slo, serr});
          check("req_ready_busy", bus.req_ready, 0);
        end
        if (hold > 0) begin
          bus.resp_ready = 1'b0;
          hold--;
        end else begin
          bus.resp_ready = 1'b1;
          in_resp  = 1'b0;
          idle_chk = 1'b1;
        end
      end else begin
        bus.resp_ready = 1'b0;
      end
    end
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    logic [1:0]  op;
    logic [15:0] x;
    logic [7:0]  y;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_x     = 16'h0000;
    bus.req_y     = 8'h00;
    end_s    = 1'b0;
    outbus_s = 8'h00;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_begin", bus.BEGIN, 0);
    check("rst_op_code", bus.op_code, 0);
    check("rst_inbus", bus.inbus, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", {bus.resp_hi, bus.resp_lo, bus.resp_err}, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(2'd0, 16'h0025, 8'h13, 2, 1'b0, 0);
    issue(2'd2, 16'h000C, 8'h0B, 1, 1'b0, 0);
    issue(2'd3, 16'h0107, 8'h10, 0, 1'b0, 1);
    issue(2'd0, 16'h0011, 8'h22, 0, 1'b1, 0);
    issue(2'd1, 16'h0050, 8'h60, 3, 1'b0, 0);
    issue(2'd2, 16'h00FF, 8'hFF, 0, 1'b0, 10);
    issue(2'd1, 16'h0003, 8'h09, 0, 1'b0, 0);
    issue(2'd0, 16'h00F0, 8'h20, TMO - 1, 1'b0, 0);
    issue(2'd3, 16'hFFFF, 8'h03, TMO - 1, 1'b0, 0);
    issue(2'd3, 16'h1234, 8'h56, 0, 1'b1, 2);
    drain();

    // Reset during LD1 abandons the operation; a later END must be ignored.
    model_on = 1'b0;
    check("rst_test_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_x     = 16'h0042;
    bus.req_y     = 8'h11;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_strt_begin", bus.BEGIN, 1);
    @(negedge clk);
    check("abort_ld0_inbus", bus.inbus, 8'h42);
    @(negedge clk);
    check("abort_ld1_inbus", bus.inbus, 8'h11);
    reset = 1'b0;
    #1;
    check("abort_begin", bus.BEGIN, 0);
    check("abort_inbus", bus.inbus, 0);
    check("abort_op_code", bus.op_code, 0);
    check("abort_resp_valid", bus.resp_valid, 0);
    check("abort_req_ready", bus.req_ready, 1);
    @(negedge clk);
    reset    = 1'b1;
    end_s    = 1'b1;
    outbus_s = 8'h5A;
    repeat (3) @(negedge clk);
    end_s    = 1'b0;
    outbus_s = 8'h00;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("no_resp_after_reset", bus.resp_valid, 0);
    end
    model_on = 1'b1;

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      x  = 16'($urandom);
      y  = 8'($urandom);
      if (op == 2'd3 && y == 8'h00) y = 8'h01;
      issue(op, x, y, $urandom_range(0, TMO - 1), ($urandom_range(0, 9) == 0),
            $urandom_range(0, 2));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
